// File: rtl/fp16_pkg.sv
// Shared half-precision field widths, class constants and converter state encoding.
// Used by the converter and its classifier; the adder can share it later.
package fp16_pkg;

    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int EXP_BIAS = 15;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 5'h1F;

    localparam logic [15:0] INT_MAX = 16'h7FFF;
    localparam logic [15:0] INT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 class decode plus denormalise shift direction/count.
// Zero latency, no handshake.
module fp16_classify
    import fp16_pkg::*;
#(
    parameter int BIAS = 15
) (
    input  logic [EXP_W-1:0] exponent,
    input  logic [MAN_W-1:0] mantissa,
    output logic             is_zero,
    output logic             is_denorm,
    output logic             is_inf,
    output logic             is_nan,
    output logic             is_small,
    output logic             shift_left,
    output logic [3:0]       shift_count
);

    // Exponent at which {1,m} (value x*2^10) already equals the integer.
    localparam logic [EXP_W-1:0] SHIFT_REF = EXP_W'(BIAS + MAN_W);
    localparam logic [EXP_W-1:0] BIAS_E    = EXP_W'(BIAS);

    logic man_zero;

    assign man_zero   = (mantissa == '0);
    assign is_zero    = (exponent == '0) && man_zero;
    assign is_denorm  = (exponent == '0) && !man_zero;
    assign is_inf     = (exponent == EXP_ALL_ONES) && man_zero;
    assign is_nan     = (exponent == EXP_ALL_ONES) && !man_zero;
    assign is_small   = (exponent < BIAS_E);
    assign shift_left = (exponent >= SHIFT_REF);

    always_comb begin
        shift_count = '0;
        if (shift_left)
            shift_count = 4'(exponent - SHIFT_REF);
        else
            shift_count = 4'(SHIFT_REF - exponent);
    end

endmodule

// File: rtl/fp16_to_int_converter.sv
// fp16 -> signed int16, truncating toward zero; one denormalise shift per cycle.
// Latency count+2 (specials 0) after accept; result held in DONE until out_Ready.
module fp16_to_int_converter
    import fp16_pkg::*;
#(
    parameter int EXP_BIAS  = 15,
    parameter int INT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_Valid,
    output logic                 in_Ready,
    input  logic                 in_Sign,
    input  logic [EXP_W-1:0]     in_Exponent,
    input  logic [MAN_W-1:0]     in_Mantissa,
    output logic                 out_Valid,
    input  logic                 out_Ready,
    output logic [INT_WIDTH-1:0] out_Integer,
    output logic                 out_OverFlow,
    output logic                 out_Invalid,
    output logic                 out_Inexact
);

    state_t      state, state_nxt;
    logic [16:0] mag;
    logic [3:0]  count;
    logic        sign, left, sticky;

    logic        is_zero, is_denorm, is_inf, is_nan, is_small;
    logic        shift_left_c;
    logic [3:0]  shift_count_c;
    logic        special;
    logic        ovf_c;

    fp16_classify #(.BIAS(EXP_BIAS)) u_classify (
        .exponent    (in_Exponent),
        .mantissa    (in_Mantissa),
        .is_zero     (is_zero),
        .is_denorm   (is_denorm),
        .is_inf      (is_inf),
        .is_nan      (is_nan),
        .is_small    (is_small),
        .shift_left  (shift_left_c),
        .shift_count (shift_count_c)
    );

    assign special = is_nan || is_inf || is_zero || is_denorm || is_small;
    // Negative side reaches one further: -32768 is representable.
    assign ovf_c   = sign ? (mag > 17'd32768) : (mag > 17'd32767);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_Ready  = 1'b0;
        out_Valid = 1'b0;
        case (state)
            IDLE: begin
                in_Ready = 1'b1;
                if (in_Valid)
                    state_nxt = special ? DONE : SHIFT;
            end
            SHIFT: begin
                if (count == '0)
                    state_nxt = NEGATE;
            end
            NEGATE: state_nxt = DONE;
            DONE: begin
                out_Valid = 1'b1;
                if (out_Ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag          <= '0;
            count        <= '0;
            sign         <= 1'b0;
            left         <= 1'b0;
            sticky       <= 1'b0;
            out_Integer  <= '0;
            out_OverFlow <= 1'b0;
            out_Invalid  <= 1'b0;
            out_Inexact  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_Valid) begin
                        sign         <= in_Sign;
                        mag          <= {6'b0, 1'b1, in_Mantissa};
                        count        <= shift_count_c;
                        left         <= shift_left_c;
                        sticky       <= 1'b0;
                        out_Integer  <= '0;
                        out_OverFlow <= 1'b0;
                        out_Invalid  <= 1'b0;
                        out_Inexact  <= 1'b0;
                        if (is_nan)
                            out_Invalid <= 1'b1;
                        else if (is_inf) begin
                            out_OverFlow <= 1'b1;
                            out_Integer  <= in_Sign ? INT_MIN : INT_MAX;
                        end else if (is_zero)
                            out_Inexact <= 1'b0;
                        else if (is_denorm || is_small)
                            out_Inexact <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        count <= count - 4'd1;
                        if (left)
                            mag <= mag << 1;
                        else begin
                            mag    <= mag >> 1;
                            sticky <= sticky | mag[0];
                        end
                    end
                end
                NEGATE: begin
                    if (ovf_c) begin
                        out_OverFlow <= 1'b1;
                        out_Integer  <= sign ? INT_MIN : INT_MAX;
                    end else begin
                        out_Integer <= sign ? 16'(-mag) : mag[15:0];
                        out_Inexact <= sticky;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_to_int_converter.sv
// Directed bench for fp16_to_int_converter with a real-arithmetic reference model.
module tb_fp16_to_int_converter;

    typedef struct {
        logic [15:0] v;
        logic        ovf;
        logic        inv;
        logic        inex;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_Valid;
    logic        in_Ready;
    logic        in_Sign;
    logic [4:0]  in_Exponent;
    logic [9:0]  in_Mantissa;
    logic        out_Valid;
    logic        out_Ready;
    logic [15:0] out_Integer;
    logic        out_OverFlow;
    logic        out_Invalid;
    logic        out_Inexact;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    fp16_to_int_converter #(.EXP_BIAS(15), .INT_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_Valid     (in_Valid),
        .in_Ready     (in_Ready),
        .in_Sign      (in_Sign),
        .in_Exponent  (in_Exponent),
        .in_Mantissa  (in_Mantissa),
        .out_Valid    (out_Valid),
        .out_Ready    (out_Ready),
        .out_Integer  (out_Integer),
        .out_OverFlow (out_OverFlow),
        .out_Invalid  (out_Invalid),
        .out_Inexact  (out_Inexact)
    );

    always #5 clk = ~clk;

    // Value of the half as a real, then truncate toward zero and saturate.
    function automatic exp_t model(input logic [15:0] h);
        exp_t r;
        logic s;
        int   e, m, tr;
        real  x;
        s = h[15];
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        r.v = 16'h0000; r.ovf = 1'b0; r.inv = 1'b0; r.inex = 1'b0;
        if (e == 31) begin
            if (m != 0) r.inv = 1'b1;
            else begin
                r.ovf = 1'b1;
                r.v   = s ? 16'h8000 : 16'h7FFF;
            end
            return r;
        end
        if (e == 0) begin
            x = $itor(m);
            for (int i = 0; i < 24; i++) x = x / 2.0;
        end else begin
            x = 1.0 + $itor(m) / 1024.0;
            for (int i = 15; i < e; i++) x = x * 2.0;
            for (int i = e; i < 15; i++) x = x / 2.0;
        end
        tr = $rtoi(x);
        if (tr > (s ? 32768 : 32767)) begin
            r.ovf = 1'b1;
            r.v   = s ? 16'h8000 : 16'h7FFF;
        end else begin
            r.v    = s ? 16'(-tr) : 16'(tr);
            r.inex = (x != $itor(tr));
        end
        return r;
    endfunction

    // Output compare: every cycle out_Valid is high the result must match the head.
    always @(negedge clk) begin
        if (rst_n && out_Valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got int=%h ovf=%b inv=%b inex=%b want no result",
                         out_Integer, out_OverFlow, out_Invalid, out_Inexact);
            end else if (out_Integer !== q[0].v || out_OverFlow !== q[0].ovf ||
                         out_Invalid !== q[0].inv || out_Inexact !== q[0].inex || in_Ready !== 1'b0) begin
                errors++;
                $display("FAIL result got int=%h ovf=%b inv=%b inex=%b rdy=%b want int=%h ovf=%b inv=%b inex=%b rdy=0",
                         out_Integer, out_OverFlow, out_Invalid, out_Inexact, in_Ready,
                         q[0].v, q[0].ovf, q[0].inv, q[0].inex);
            end
            if (out_Ready && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic scramble();
        in_Valid    = 1'($urandom_range(0, 1));
        in_Sign     = 1'($urandom_range(0, 1));
        in_Exponent = 5'($urandom_range(0, 31));
        in_Mantissa = 10'($urandom_range(0, 1023));
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic send(input logic [15:0] h, input logic [15:0] lv, input logic lo,
                        input logic li, input logic lx, input int hold, input bit garble);
        exp_t m;
        int   e, lat, exp_lat;
        m = model(h);
        checks++;
        if (m.v !== lv || m.ovf !== lo || m.inv !== li || m.inex !== lx) begin
            errors++;
            $display("FAIL model_pin %h got int=%h ovf=%b inv=%b inex=%b want int=%h ovf=%b inv=%b inex=%b",
                     h, m.v, m.ovf, m.inv, m.inex, lv, lo, li, lx);
        end
        e = int'(h[14:10]);
        exp_lat = (e == 31 || e < 15) ? 0 : ((e >= 25) ? e - 25 : 25 - e) + 2;
        q.push_back(lv == m.v ? m : m);
        in_Valid    = 1'b1;
        in_Sign     = h[15];
        in_Exponent = h[14:10];
        in_Mantissa = h[9:0];
        @(posedge clk); #1;
        if (garble) scramble(); else in_Valid = 1'b0;
        lat = 0;
        while (!out_Valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (garble) scramble();
        end
        in_Valid = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency %h got %0d want %0d", h, lat, exp_lat);
        end
        repeat (hold) begin @(posedge clk); #1; end
        out_Ready = 1'b1;
        @(posedge clk); #1;
        out_Ready = 1'b0;
        checks++;
        if (in_Ready !== 1'b1 || out_Valid !== 1'b0) begin
            errors++;
            $display("FAIL release %h got rdy=%b vld=%b want rdy=1 vld=0", h, in_Ready, out_Valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; in_Valid = 1'b0; out_Ready = 1'b0;
        in_Sign = 1'b0; in_Exponent = '0; in_Mantissa = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_Ready !== 1'b1 || out_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0", in_Ready, out_Valid);
        end
        checks++;
        if (out_Integer !== 16'h0 || out_OverFlow !== 1'b0 || out_Invalid !== 1'b0 || out_Inexact !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got int=%h flags=%b%b%b want 0000 000",
                     out_Integer, out_OverFlow, out_Invalid, out_Inexact);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        send(16'h3C00, 16'h0001, 0, 0, 0, 0, 0);
        send(16'hC500, 16'hFFFB, 0, 0, 0, 5, 0);
        send(16'h3E00, 16'h0001, 0, 0, 1, 0, 0);
        send(16'hB400, 16'h0000, 0, 0, 1, 0, 0);
        send(16'h7BFF, 16'h7FFF, 1, 0, 0, 0, 0);
        send(16'hF800, 16'h8000, 0, 0, 0, 0, 0);
        send(16'hFC00, 16'h8000, 1, 0, 0, 5, 0);
        send(16'h7E00, 16'h0000, 0, 1, 0, 0, 0);
        send(16'h7C00, 16'h7FFF, 1, 0, 0, 0, 0);
        send(16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        send(16'h8001, 16'h0000, 0, 0, 1, 0, 0);
        send(16'h6400, 16'h0400, 0, 0, 0, 0, 0);
        send(16'h7800, 16'h7FFF, 1, 0, 0, 0, 0);
        send(16'h5A48, 16'h00C9, 0, 0, 0, 0, 1);
        send(16'hBC01, 16'hFFFF, 0, 0, 1, 2, 1);

        // Abort 1.0 mid-shift with reset; it must never produce a result.
        in_Valid = 1'b1; in_Sign = 1'b0; in_Exponent = 5'h0F; in_Mantissa = 10'h000;
        @(posedge clk); #1;
        in_Valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_Valid !== 1'b0 || in_Ready !== 1'b1 || out_Integer !== 16'h0) begin
            errors++;
            $display("FAIL abort_reset got vld=%b rdy=%b int=%h want vld=0 rdy=1 int=0000",
                     out_Valid, in_Ready, out_Integer);
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_Valid) seen++; end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_result got %0d valid cycles want 0", seen);
        end
        send(16'h4900, 16'h000A, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_to_int_converter.md
Name: fp16_to_int_converter

Overview:
Sequential converter from IEEE-754 half precision (sign / 5-bit exponent / 10-bit mantissa fields, the same field format the half-precision adder consumes) to a signed two's-complement integer.
It undoes the adder's normalise step: it denormalises the significand one bit per cycle and rounds toward zero. It also flags overflow, NaN and inexact results.
A valid/ready handshake sits on both sides, so it can sit between the FP datapath and integer consumers.

Parameters:
EXP_BIAS, 15, exponent bias of the input format
INT_WIDTH, 16, output integer width; only 16 is supported and verified

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_Valid  input  1  input operand valid
in_Ready  output  1  converter can accept an operand; high only in IDLE
in_Sign  input  1  sign bit
in_Exponent  input  5  biased exponent
in_Mantissa  input  10  fraction bits; implicit 1 not included
out_Valid  output  1  result valid; held until accepted
out_Ready  input  1  consumer accepts the result
out_Integer  output  16  signed result, truncated toward zero
out_OverFlow  output  1  magnitude out of range, or infinity; result saturated
out_Invalid  output  1  input was NaN
out_Inexact  output  1  nonzero fraction bits were discarded

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_Ready=1, out_Valid=0.
  - out_Integer=0, all flags=0, internal shift count=0.
  - Reset asserted mid-operation aborts it; no result is produced.
- Accept: on a rising edge with in_Valid & in_Ready, capture all three fields. Later input changes are ignored until the next IDLE.
- FSM states: IDLE, SHIFT, NEGATE, DONE.
  - IDLE -> DONE: for special classes (listed below).
  - IDLE -> SHIFT: otherwise.
  - SHIFT -> NEGATE: when count==0.
  - NEGATE -> DONE.
  - DONE -> IDLE: on out_Valid & out_Ready.
  - A new operand is never accepted in the same cycle as a DONE handshake.
- Special classes, resolved at accept, entering DONE directly (out_Valid one cycle after the accept edge):
  - e=31, m!=0 (NaN): out_Integer=0, out_Invalid=1.
  - e=31, m=0 (infinity): saturate to 0x7FFF (+) or 0x8000 (-), out_OverFlow=1.
  - e=0, m=0 (±0): 0, no flags.
  - e=0, m!=0 (denormal) or 1<=e<=14: 0, out_Inexact=1.
- Normal path, 15<=e<=30:
  - Load the 17-bit magnitude register with {6'b0, 1, m}; this value equals x*2^10.
  - e<25: right-shift count = 25-e, range 1..10. Every bit shifted out is ORed into a sticky bit, which drives out_Inexact.
  - e>=25: left-shift count = e-25, range 0..5; left shifts are always exact.
  - SHIFT state: if count!=0, shift one bit and decrement count; else go to NEGATE.
- NEGATE state:
  - Overflow when magnitude > 32767 for positive inputs, or > 32768 for negative inputs. Then saturate as for infinity and set out_OverFlow=1.
  - Otherwise out_Integer = sign ? -magnitude : magnitude, computed modulo 2^16.
- Latency, measured from the accept edge: out_Valid rises after edge count+2 for the normal path, and after edge 0 for special classes.
- Throughput: at most one operand per count+4 cycles.
- DONE: out_Valid=1. out_Integer and all flags stay stable while out_Ready=0.
- Flags: cleared on the accept edge; never set simultaneously except that out_Inexact=0 whenever out_OverFlow or out_Invalid is set.

Decomposition:
- Shared package fp16_pkg:
  - field widths (EXP_W=5, MAN_W=10)
  - EXP_BIAS
  - EXP_ALL_ONES
  - state enum {IDLE, SHIFT, NEGATE, DONE}
  - saturation constants INT_MAX=0x7FFF, INT_MIN=0x8000
- One combinational sub-module, fp16_classify: from exponent and mantissa, produce is_zero, is_denorm, is_inf, is_nan, is_small (e<15) and the shift direction and count. The adder's special-condition logic can reuse it later.

Test Plan:
- 0x3C00 (1.0): out_Integer=0x0001, no flags; out_Valid rises after edge 12 (count=10).
- 0xC500 (-5.0) -> 0xFFFB, exact.
- 0x3E00 (1.5) -> 0x0001, out_Inexact=1.
- 0xB400 (-0.25) -> 0x0000, out_Inexact=1; out_Valid one cycle after accept.
- 0x7BFF (65504) -> 0x7FFF, out_OverFlow=1.
- 0xF800 (-32768) -> 0x8000, out_OverFlow=0, exact.
- 0xFC00 (-inf) -> 0x8000, out_OverFlow=1.
- 0x7E00 (NaN) -> 0x0000, out_Invalid=1.
- Backpressure: hold out_Ready=0 for 5 cycles in DONE; out_Integer and flags must stay stable and in_Ready=0. After the handshake, in_Ready=1 on the next cycle.
- Drive rst_n low during SHIFT for 0x3C00, then release and send 0x4900 (10.0): the aborted operand gives no out_Valid; then out_Integer=0x000A.
- Toggle in_Valid/in_Sign/in_Exponent/in_Mantissa during SHIFT: the result must be unaffected.
